pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32IMC pipeline. Consumes the forwarding unit's load-use hazard flags, the EXE-stage taken-branch/jump indication, and the multi-cycle M-extension start/done handshake. Drives per-register hold (stall) and bubble (flush) enables for PC, IF/ID, ID/EXE and EXE/MEM. Includes a one-cycle load-use hold state and a bounded multi-cycle wait with timeout.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 25 ++
 rtl/stall_perf_counter.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings, defaults and control bundle for the hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0] PHC_RUN      = 2'd0;
    localparam logic [1:0] PHC_LU_HOLD  = 2'd1;
    localparam logic [1:0] PHC_DIV_WAIT = 2'd2;

    localparam int MC_TIMEOUT_DEF = 64;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_exe;
        logic stall_mem;
        logic flush_id;
        logic flush_exe;
        logic flush_mem;
    } hzd_ctrl_t;

    localparam hzd_ctrl_t CTRL_NONE   = hzd_ctrl_t'(7'b000_0000);
    localparam hzd_ctrl_t CTRL_EXE_LU = hzd_ctrl_t'(7'b111_0001);
    localparam hzd_ctrl_t CTRL_BRANCH = hzd_ctrl_t'(7'b000_0110);
    localparam hzd_ctrl_t CTRL_ID_LU  = hzd_ctrl_t'(7'b110_0010);

endpackage

// File: rtl/stall_perf_counter.sv
// Free-running 32-bit wrapping event counter with enable.
module stall_perf_counter (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            count <= '0;
        else if (en)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use hold, branch squash, bounded mul/div wait.
// Optional perf counters under STALL_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
    parameter int MC_CNT_W   = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic hzd_exe_to_id_A,
    input  logic hzd_mem_to_id_A,
    input  logic hzd_mem_to_exe_A,
    input  logic hzd_mem_to_exe_B,
    input  logic exe_br_taken,
    input  logic exe_mc_start,
    input  logic exe_mc_done,
    output logic stall_if,
    output logic stall_id,
    output logic stall_exe,
    output logic stall_mem,
    output logic flush_id,
    output logic flush_exe,
    output logic flush_mem,
    output logic mc_timeout_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_events
`endif
);

    localparam logic [MC_CNT_W-1:0] CNT_LAST = MC_CNT_W'(MC_TIMEOUT - 1);
    localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [MC_CNT_W-1:0] cnt_q, cnt_d;
    logic                err_d;
    logic                id_hzd, exe_hzd, hzd_live;
    hzd_ctrl_t           ctrl;

    assign id_hzd   = hzd_exe_to_id_A | hzd_mem_to_id_A;
    assign exe_hzd  = hzd_mem_to_exe_A | hzd_mem_to_exe_B;
    // The load has already advanced during LU_HOLD; forwarding covers it.
    assign hzd_live = (state_q == PHC_RUN);

    always_comb begin
        ctrl    = CTRL_NONE;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = mc_timeout_err;
        case (state_q)
            PHC_DIV_WAIT: begin
                if (exe_mc_done) begin
                    state_d = PHC_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PHC_RUN;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    ctrl  = CTRL_EXE_LU;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = PHC_RUN;
                if (exe_mc_start && !exe_mc_done) begin
                    ctrl    = CTRL_EXE_LU;
                    state_d = PHC_DIV_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (exe_mc_start) begin
                    state_d = PHC_RUN;
                end else if (exe_hzd && hzd_live) begin
                    ctrl    = CTRL_EXE_LU;
                    state_d = PHC_LU_HOLD;
                end else if (exe_br_taken) begin
                    ctrl    = CTRL_BRANCH;
                end else if (id_hzd && hzd_live) begin
                    ctrl    = CTRL_ID_LU;
                    state_d = PHC_LU_HOLD;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q        <= PHC_RUN;
            cnt_q          <= '0;
            mc_timeout_err <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mc_timeout_err <= err_d;
        end
    end

    assign stall_if  = nrst & ctrl.stall_if;
    assign stall_id  = nrst & ctrl.stall_id;
    assign stall_exe = nrst & ctrl.stall_exe;
    assign stall_mem = nrst & ctrl.stall_mem;
    assign flush_id  = nrst & ctrl.flush_id;
    assign flush_exe = nrst & ctrl.flush_exe;
    assign flush_mem = nrst & ctrl.flush_mem;

`ifdef STALL_PERF_CNT_EN
    stall_perf_counter u_stall_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .en    (stall_if),
        .count (perf_stall_cycles)
    );

    stall_perf_counter u_flush_cnt (
        .clk   (clk),
        .nrst  (nrst),
        .en    (flush_id),
        .count (perf_flush_events)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed plan steps then random traffic vs a rule model.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 8;

    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_STALL = 8'b0111_0001;
    localparam logic [7:0] E_BR = 8'b0000_0110;
    localparam logic [7:0] E_IDH = 8'b0110_0010;

    typedef enum int { M_RUN, M_HOLD, M_WAIT } mmode_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic hzd_exe_to_id_A = 1'b0;
    logic hzd_mem_to_id_A = 1'b0;
    logic hzd_mem_to_exe_A = 1'b0;
    logic hzd_mem_to_exe_B = 1'b0;
    logic exe_br_taken = 1'b0;
    logic exe_mc_start = 1'b0;
    logic exe_mc_done = 1'b0;
    logic stall_if, stall_id, stall_exe, stall_mem;
    logic flush_id, flush_exe, flush_mem;
    logic mc_timeout_err;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

    int nchk = 0;
    int npass = 0;
    int nfail = 0;

    mmode_t m_mode = M_RUN;
    int m_waited = 0;
    bit m_err = 1'b0;
    int m_stalls = 0;
    int m_flushes = 0;

    pipeline_hazard_ctrl #(.MC_TIMEOUT(TMO), .MC_CNT_W(16)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .hzd_exe_to_id_A  (hzd_exe_to_id_A),
        .hzd_mem_to_id_A  (hzd_mem_to_id_A),
        .hzd_mem_to_exe_A (hzd_mem_to_exe_A),
        .hzd_mem_to_exe_B (hzd_mem_to_exe_B),
        .exe_br_taken     (exe_br_taken),
        .exe_mc_start     (exe_mc_start),
        .exe_mc_done      (exe_mc_done),
        .stall_if         (stall_if),
        .stall_id         (stall_id),
        .stall_exe        (stall_exe),
        .stall_mem        (stall_mem),
        .flush_id         (flush_id),
        .flush_exe        (flush_exe),
        .flush_mem        (flush_mem),
        .mc_timeout_err   (mc_timeout_err)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_events (perf_flush_events)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {1'b0, stall_if, stall_id, stall_exe, stall_mem,
                flush_id, flush_exe, flush_mem};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {hzd_exe_to_id_A, hzd_mem_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B,
         exe_br_taken, exe_mc_start, exe_mc_done} = v;
    endtask

    // v = {exe_to_id_A, mem_to_id_A, mem_to_exe_A, mem_to_exe_B, br, start, done}
    task automatic step(input string tag, input logic [6:0] v);
        logic [7:0] e;
        mmode_t nm;
        bit nerr;
        bit id_h, ex_h, br, st, dn, live;
        @(negedge clk);
        drive(v);
        #2;
        id_h = v[6] | v[5];
        ex_h = v[4] | v[3];
        br = v[2];
        st = v[1];
        dn = v[0];
        e = E_NONE;
        nm = M_RUN;
        nerr = m_err;
        if (m_mode == M_WAIT) begin
            if (!dn && m_waited == TMO - 1)
                nerr = 1'b1;
            else if (!dn) begin
                e = E_STALL;
                nm = M_WAIT;
                m_waited++;
            end
        end else begin
            live = (m_mode == M_RUN);
            if (st && !dn) begin
                e = E_STALL;
                nm = M_WAIT;
                m_waited = 1;
            end else if (st) begin
                e = E_NONE;
            end else if (live && ex_h) begin
                e = E_STALL;
                nm = M_HOLD;
            end else if (br) begin
                e = E_BR;
            end else if (live && id_h) begin
                e = E_IDH;
                nm = M_HOLD;
            end
        end
        chk({tag, "_out"}, 32'(outs()), 32'(e));
        chk({tag, "_err"}, 32'(mc_timeout_err), 32'(m_err));
        chk({tag, "_excl"}, {29'd0, stall_id & flush_id,
            stall_exe & flush_exe, stall_mem & flush_mem}, 32'd0);
        m_stalls += int'(e[6]);
        m_flushes += int'(e[2]);
        m_mode = nm;
        m_err = nerr;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        nrst = 1'b0;
        drive(7'b0011110);
        #1;
        chk({tag, "_rst_out"}, 32'(outs()), 32'(E_NONE));
        chk({tag, "_rst_err"}, 32'(mc_timeout_err), 32'd0);
        m_mode = M_RUN;
        m_waited = 0;
        m_err = 1'b0;
        m_stalls = 0;
        m_flushes = 0;
        @(negedge clk);
        drive(7'b0);
        nrst = 1'b1;
    endtask

    initial begin
        do_reset("init");

        step("lu_b1", 7'b0001000);
        step("lu_b2", 7'b0001000);
        step("lu_idle", 7'b0000000);

        step("jalr_br", 7'b1000100);
        step("jalr_after", 7'b0100000);
        step("jalr_hold", 7'b0000000);

        step("mc_start", 7'b0000010);
        for (int i = 0; i < 5; i++) step("mc_wait", 7'b0011100);
        step("mc_done", 7'b0000001);
        step("mc_idle", 7'b0000000);

        step("tmo_start", 7'b0000010);
        for (int i = 0; i < 6; i++) step("tmo_wait", 7'b0000000);
        step("tmo_release", 7'b0000000);
        step("tmo_sticky", 7'b0000000);
        step("tmo_sticky2", 7'b0001000);

        step("mid_start", 7'b0000010);
        for (int i = 0; i < 4; i++) step("mid_wait", 7'b0000000);
        do_reset("mid");
        step("mid_run", 7'b1000000);
        step("mid_hold", 7'b0000000);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] v;
            v[6] = ($urandom_range(0, 5) == 0);
            v[5] = ($urandom_range(0, 5) == 0);
            v[4] = ($urandom_range(0, 5) == 0);
            v[3] = ($urandom_range(0, 5) == 0);
            v[2] = ($urandom_range(0, 4) == 0);
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 7) == 0);
            step("rnd", v);
        end

`ifdef STALL_PERF_CNT_EN
        @(negedge clk);
        chk("perf_stall", perf_stall_cycles, 32'(m_stalls));
        chk("perf_flush", perf_flush_events, 32'(m_flushes));
        do_reset("perf");
        step("perf_lu1", 7'b0001000);
        step("perf_h1", 7'b0000000);
        step("perf_br1", 7'b0000100);
        step("perf_lu2", 7'b0010000);
        step("perf_h2", 7'b0000000);
        step("perf_br2", 7'b0000100);
        step("perf_lu3", 7'b1000000);
        step("perf_h3", 7'b0000000);
        @(negedge clk);
        chk("perf_stall3", perf_stall_cycles, 32'd3);
        chk("perf_flush2", perf_flush_events, 32'd2);
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
